// File: rtl/ex_pkg.sv
// Shared widths, op codes, state encoding and the single-cycle ALU for the
// execute stage.
package ex_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int DEST_SRC_W = 2;
  localparam int REG_IDX_W  = 5;
  localparam int ALU_OP_W   = 4;
  localparam int SHAMT_W    = $clog2(WORD_W);
  localparam int CNT_W      = $clog2(WORD_W);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } alu_op_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Fields carried unchanged from decode to the memory stage.
  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [INSTR_W-1:0]    instr;
    logic [DEST_SRC_W-1:0] dest_src;
    logic [REG_IDX_W-1:0]  dest_reg;
  } fields_t;

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // Multi-cycle and undefined op codes evaluate to 0 here.
  function automatic word_t alu_eval(input logic [ALU_OP_W-1:0] op,
                                     input word_t a, input word_t b);
    word_t              res;
    logic [SHAMT_W-1:0] sh;
    sh  = b[SHAMT_W-1:0];
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLT:  res = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(WORD_W-1){1'b0}}, (a < b)};
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = word_t'($signed(a) >>> sh);
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_if.sv
// Decode-to-execute-to-memory connection of the execute stage.
interface ex_if;
  import ex_pkg::*;

  logic                  i_valid;
  logic                  i_flush;
  logic [ADDR_W-1:0]     i_pc;
  logic [INSTR_W-1:0]    i_instr;
  logic [DEST_SRC_W-1:0] i_dest_src;
  logic [REG_IDX_W-1:0]  i_dest_reg;
  logic [ALU_OP_W-1:0]   i_alu_op;
  word_t                 i_op_a;
  word_t                 i_op_b;

  logic                  o_stall;
  logic [ADDR_W-1:0]     o_pc;
  logic [INSTR_W-1:0]    o_instr;
  logic [DEST_SRC_W-1:0] o_dest_src;
  logic [REG_IDX_W-1:0]  o_dest_reg;
  word_t                 o_alu_eval;

  modport master (
    output i_valid, i_flush, i_pc, i_instr, i_dest_src, i_dest_reg,
           i_alu_op, i_op_a, i_op_b,
    input  o_stall, o_pc, o_instr, o_dest_src, o_dest_reg, o_alu_eval
  );

  modport slave (
    input  i_valid, i_flush, i_pc, i_instr, i_dest_src, i_dest_reg,
           i_alu_op, i_op_a, i_op_b,
    output o_stall, o_pc, o_instr, o_dest_src, o_dest_reg, o_alu_eval
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide/remainder
// (restoring shift-subtract), one bit per cycle for WORD_W cycles.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                kill,
  input  logic [ALU_OP_W-1:0] op,
  input  word_t               a,
  input  word_t               b,
  output logic                busy,
  output logic                done,
  output word_t               result
);

  // acc: product or partial remainder; x: multiplicand or dividend/quotient;
  // y: multiplier or divisor.
  word_t               acc, x, y;
  word_t               acc_n, x_n, y_n;
  logic [ALU_OP_W-1:0] op_r;
  logic [CNT_W-1:0]    cnt;
  logic                busy_r;
  logic [WORD_W:0]     rem_sh, diff;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    acc_n  = acc;
    x_n    = x;
    y_n    = y;
    rem_sh = '0;
    diff   = '0;
    if (op_r == ALU_MUL) begin
      acc_n = y[0] ? acc + x : acc;
      x_n   = x << 1;
      y_n   = y >> 1;
    end else begin
      // A zero divisor never borrows: quotient fills with ones and the
      // remainder shifts in the whole dividend.
      rem_sh = {acc, x[WORD_W-1]};
      diff   = rem_sh - {1'b0, y};
      acc_n  = diff[WORD_W] ? rem_sh[WORD_W-1:0] : diff[WORD_W-1:0];
      x_n    = {x[WORD_W-2:0], ~diff[WORD_W]};
    end
  end

  // The final iteration is folded in combinationally so the result is ready
  // during the cnt==0 cycle.
  assign result = (op_r == ALU_DIVU) ? x_n : acc_n;
  assign busy   = busy_r;
  assign done   = busy_r && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      busy_r <= 1'b0;
      cnt    <= '0;
    end else if (kill) begin
      busy_r <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt    <= CNT_W'(WORD_W - 1);
    end else if (busy_r) begin
      if (cnt == '0) busy_r <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  // NOTE: datapath registers carry no reset; they are loaded on start and only
  // observed while busy_r, which is reset.
  always_ff @(posedge clk) begin
    if (start) begin
      acc  <= '0;
      x    <= a;
      y    <= b;
      op_r <= op;
    end else if (busy_r) begin
      acc <= acc_n;
      x   <= x_n;
      y   <= y_n;
    end
  end

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle ALU plus IDLE/BUSY handshake around the
// iterative mul/div unit, registering results for the memory stage.
module ex
  import ex_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic clk,
  input  logic clr,
  ex_if.slave  bus
);

  logic [0:0] state, nxt_state;
  fields_t    in_f, held, nxt_f;
  word_t      alu_res, md_result, nxt_eval;
  logic       in_md, md_start, md_busy, md_done;

  assign in_f    = '{pc: bus.i_pc, instr: bus.i_instr,
                     dest_src: bus.i_dest_src, dest_reg: bus.i_dest_reg};
  assign in_md   = MULDIV_EN && is_muldiv(bus.i_alu_op);
  assign alu_res = alu_eval(bus.i_alu_op, bus.i_op_a, bus.i_op_b);

  assign md_start = clr && !bus.i_flush && (state == ST_IDLE) &&
                    bus.i_valid && in_md;

  // Decode holds through acceptance and every BUSY cycle except the last.
  assign bus.o_stall = clr && !bus.i_flush &&
                       ((state == ST_IDLE) ? (bus.i_valid && in_md)
                                           : (md_busy && !md_done));

  generate
    if (MULDIV_EN) begin : g_muldiv
      ex_muldiv u_muldiv (
        .clk    (clk),
        .clr    (clr),
        .start  (md_start),
        .kill   (bus.i_flush),
        .op     (bus.i_alu_op),
        .a      (bus.i_op_a),
        .b      (bus.i_op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_muldiv
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (md_start) held <= in_f;
  end

  always_comb begin
    nxt_state = state;
    nxt_f     = '0;
    nxt_eval  = '0;
    if (bus.i_flush) begin
      nxt_state = ST_IDLE;
    end else if (state == ST_BUSY) begin
      if (md_done) begin
        nxt_f     = held;
        nxt_eval  = md_result;
        nxt_state = ST_IDLE;
      end
    end else if (bus.i_valid && in_md) begin
      nxt_state = ST_BUSY;
    end else if (bus.i_valid) begin
      nxt_f    = in_f;
      nxt_eval = alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state          <= ST_IDLE;
      bus.o_pc       <= '0;
      bus.o_instr    <= '0;
      bus.o_dest_src <= '0;
      bus.o_dest_reg <= '0;
      bus.o_alu_eval <= '0;
    end else begin
      state          <= nxt_state;
      bus.o_pc       <= nxt_f.pc;
      bus.o_instr    <= nxt_f.instr;
      bus.o_dest_src <= nxt_f.dest_src;
      bus.o_dest_reg <= nxt_f.dest_reg;
      bus.o_alu_eval <= nxt_eval;
    end
  end

endmodule
